// File: rtl/instr_realigner.sv
// instr_realigner: turns word-aligned 32-bit fetch words into a stream of
// bit-0-aligned instructions with their PCs. It handles compressed 16-bit
// instructions, 32-bit instructions straddling a word boundary, and redirects
// to halfword-aligned targets.
// Optional build macro: INSTR_REALIGNER_PERF_EN adds misalign_cnt_o, a
// saturating count of accepted word-straddling instructions.
module instr_realigner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
`ifdef INSTR_REALIGNER_PERF_EN
  ,
  output logic [31:0] misalign_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ALIGNED,
    MISALIGNED,
    BRANCH_MIS
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [15:0] r_h;
  logic [15:0] nxt_h;
  logic [31:0] r_pc;
  logic        valid;
  logic        ready;
  logic [31:0] aligned;
  logic        compressed;
  logic        discard;
  logic        accept;

  // Output selection and next-state decision from state, held halfword and fetch word
  always_comb begin
    valid     = 1'b0;
    ready     = 1'b0;
    aligned   = 32'h0;
    nxt_state = state;
    nxt_h     = r_h;
    discard   = 1'b0;
    if (!rst && !branch_i) begin
      case (state)
        ALIGNED: begin
          valid = fetch_valid_i;
          ready = id_ready_i;
          if (fetch_rdata_i[1:0] == 2'b11) begin
            aligned = fetch_rdata_i;
          end else begin
            aligned   = {16'h0, fetch_rdata_i[15:0]};
            nxt_state = MISALIGNED;
            nxt_h     = fetch_rdata_i[31:16];
          end
        end
        MISALIGNED: begin
          if (r_h[1:0] != 2'b11) begin
            valid     = 1'b1;
            aligned   = {16'h0, r_h};
            nxt_state = ALIGNED;
          end else begin
            valid   = fetch_valid_i;
            ready   = id_ready_i;
            aligned = {fetch_rdata_i[15:0], r_h};
            nxt_h   = fetch_rdata_i[31:16];
          end
        end
        BRANCH_MIS: begin
          if (fetch_rdata_i[17:16] != 2'b11) begin
            valid     = fetch_valid_i;
            ready     = id_ready_i;
            aligned   = {16'h0, fetch_rdata_i[31:16]};
            nxt_state = ALIGNED;
          end else begin
            ready     = fetch_valid_i;
            discard   = fetch_valid_i;
            nxt_h     = fetch_rdata_i[31:16];
            nxt_state = MISALIGNED;
          end
        end
        default: begin
          nxt_state = ALIGNED;
        end
      endcase
    end
  end

  assign compressed         = !rst && (aligned[1:0] != 2'b11);
  assign accept             = valid && id_ready_i;
  assign instr_valid_o      = valid;
  assign fetch_ready_o      = ready;
  assign instr_aligned_o    = aligned;
  assign instr_compressed_o = compressed;
  assign pc_o               = r_pc;

  // State, held halfword and PC advance on accept, redirect or discarded half-word fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALIGNED;
      r_h   <= 16'h0;
      r_pc  <= BOOT_ADDR;
    end else if (branch_i) begin
      r_pc  <= branch_addr_i & ~32'h1;
      state <= branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
      r_h   <= 16'h0;
    end else if (accept) begin
      r_pc  <= r_pc + (compressed ? 32'd2 : 32'd4);
      state <= nxt_state;
      r_h   <= nxt_h;
    end else if (discard) begin
      state <= nxt_state;
      r_h   <= nxt_h;
    end
  end

`ifdef INSTR_REALIGNER_PERF_EN
  logic straddle;
  assign straddle = accept && (state == MISALIGNED) && (r_h[1:0] == 2'b11);

  // Saturating count of accepted instructions assembled across a word boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_cnt_o <= 32'h0;
    end else if (straddle && (misalign_cnt_o != 32'hFFFF_FFFF)) begin
      misalign_cnt_o <= misalign_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// tb_instr_realigner: directed scenarios plus a randomized run against a
// halfword-memory program model (the bench plays the prefetcher).
module tb_instr_realigner;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_aligned;
  logic        instr_compressed;
  logic [31:0] pc;
  logic        id_ready;
  logic        branch;
  logic [31:0] branch_addr;
`ifdef INSTR_REALIGNER_PERF_EN
  logic [31:0] misalign_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem [0:1023];

  instr_realigner dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid),
    .fetch_rdata_i      (fetch_rdata),
    .fetch_ready_o      (fetch_ready),
    .instr_valid_o      (instr_valid),
    .instr_aligned_o    (instr_aligned),
    .instr_compressed_o (instr_compressed),
    .pc_o               (pc),
    .id_ready_i         (id_ready),
    .branch_i           (branch),
    .branch_addr_i      (branch_addr)
`ifdef INSTR_REALIGNER_PERF_EN
    ,
    .misalign_cnt_o     (misalign_cnt)
`endif
  );

  // Free-running core clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] hw(input logic [31:0] addr);
    return mem[(addr >> 1) & 32'd1023];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return {hw(addr + 32'd2), hw(addr)};
  endfunction

  task automatic applyStimulus(input logic r, input logic fv, input logic [31:0] rd,
                               input logic idr, input logic br, input logic [31:0] ba);
    @(negedge clk);
    rst = r; fetch_valid = fv; fetch_rdata = rd; id_ready = idr; branch = br; branch_addr = ba;
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (fetch_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_fready: got %b expected 0", fetch_ready); end
    checks++; if (instr_aligned !== 32'h0) begin fails++; $display("[TB] FAIL rst_instr: got %h expected 0", instr_aligned); end
    checks++; if (instr_compressed !== 1'b0) begin fails++; $display("[TB] FAIL rst_comp: got %b expected 0", instr_compressed); end
    checks++; if (pc !== 32'h80) begin fails++; $display("[TB] FAIL rst_pc: got %h expected 80", pc); end
  endtask

  task automatic test_aligned_32();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h0000_0013) begin fails++; $display("[TB] FAIL a32_instr: got %h expected 00000013", instr_aligned); end
    checks++; if (instr_compressed !== 1'b0) begin fails++; $display("[TB] FAIL a32_comp: got %b expected 0", instr_compressed); end
    checks++; if (pc !== 32'h80) begin fails++; $display("[TB] FAIL a32_pc: got %h expected 80", pc); end
    checks++; if (fetch_ready !== 1'b1 || instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL a32_hs: got %b%b expected 11", fetch_ready, instr_valid); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++; if (pc !== 32'h84) begin fails++; $display("[TB] FAIL a32_pc_next: got %h expected 84", pc); end
  endtask

  task automatic test_compressed_pair();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h4505_4501, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h4501 || pc !== 32'h80) begin fails++; $display("[TB] FAIL cp_first: got %h@%h expected 4501@80", instr_aligned, pc); end
    checks++; if (fetch_ready !== 1'b1 || instr_compressed !== 1'b1) begin fails++; $display("[TB] FAIL cp_first_hs: got %b%b expected 11", fetch_ready, instr_compressed); end
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h4505 || pc !== 32'h82) begin fails++; $display("[TB] FAIL cp_second: got %h@%h expected 4505@82", instr_aligned, pc); end
    checks++; if (fetch_ready !== 1'b0 || instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL cp_second_hs: got %b%b expected 01", fetch_ready, instr_valid); end
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h13 || pc !== 32'h84 || fetch_ready !== 1'b1) begin fails++; $display("[TB] FAIL cp_third: got %h@%h r%b expected 13@84 r1", instr_aligned, pc, fetch_ready); end
  endtask

  task automatic test_straddle();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h4501 || pc !== 32'h80) begin fails++; $display("[TB] FAIL st_first: got %h@%h expected 4501@80", instr_aligned, pc); end
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h0000_0513 || pc !== 32'h82) begin fails++; $display("[TB] FAIL st_instr: got %h@%h expected 00000513@82", instr_aligned, pc); end
    checks++; if (instr_compressed !== 1'b0 || fetch_ready !== 1'b1 || instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL st_flags: got c%b r%b v%b expected c0 r1 v1", instr_compressed, fetch_ready, instr_valid); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (pc !== 32'h86 || instr_valid !== 1'b1 || instr_aligned !== 32'h0) begin fails++; $display("[TB] FAIL st_after: got %h@%h v%b expected 0@86 v1", instr_aligned, pc, instr_valid); end
`ifdef INSTR_REALIGNER_PERF_EN
    checks++; if (misalign_cnt !== 32'd1) begin fails++; $display("[TB] FAIL st_cnt: got %0d expected 1", misalign_cnt); end
`endif
  endtask

  task automatic test_branch_compressed();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 32'h0000_0103);
    checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin fails++; $display("[TB] FAIL bc_branch: got v%b r%b expected v0 r0", instr_valid, fetch_ready); end
    applyStimulus(1'b0, 1'b1, 32'h4505_0000, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_aligned !== 32'h4505 || pc !== 32'h102) begin fails++; $display("[TB] FAIL bc_instr: got v%b %h@%h expected v1 4505@102", instr_valid, instr_aligned, pc); end
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h13 || pc !== 32'h104) begin fails++; $display("[TB] FAIL bc_next: got %h@%h expected 13@104", instr_aligned, pc); end
  endtask

  task automatic test_branch_straddle();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0202);
    applyStimulus(1'b0, 1'b1, 32'h0013_0000, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin fails++; $display("[TB] FAIL bs_discard: got v%b r%b expected v0 r1", instr_valid, fetch_ready); end
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h0000_0013 || pc !== 32'h202 || instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL bs_instr: got v%b %h@%h expected v1 00000013@202", instr_valid, instr_aligned, pc); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 32'hABCD_1234, 1'b0, 1'b0, 32'h0);
      checks++; if (instr_aligned !== 32'h1234_0513 || pc !== 32'h82 || instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL sr_hold%0d: got v%b %h@%h expected v1 12340513@82", k, instr_valid, instr_aligned, pc); end
    end
    applyStimulus(1'b1, 1'b1, 32'hABCD_1234, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_aligned !== 32'h13 || pc !== 32'h80) begin fails++; $display("[TB] FAIL sr_after: got %h@%h expected 13@80", instr_aligned, pc); end
  endtask

  task automatic test_random();
    logic [31:0] fa, mpc, addr_r, rd, exp_i;
    logic        br_r, fv_r, idr_r, exp_c, acc, cons;
    int          n_acc, exp_cnt;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
    end
    do_reset();
    fa = 32'h80; mpc = 32'h80; n_acc = 0; exp_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      br_r   = ($urandom_range(0, 24) == 0);
      addr_r = $urandom_range(0, 2047);
      fv_r   = ($urandom_range(0, 4) != 0);
      idr_r  = ($urandom_range(0, 3) != 0);
      rd     = fv_r ? word_at(fa) : $urandom;
      applyStimulus(1'b0, fv_r, rd, idr_r, br_r, addr_r);
      exp_c = (hw(mpc) & 16'h3) != 16'h3;
      exp_i = exp_c ? {16'h0, hw(mpc)} : {hw(mpc + 32'd2), hw(mpc)};
      checks++; if (pc !== mpc) begin fails++; $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", i, pc, mpc); end
      if (br_r) begin
        checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin fails++; $display("[TB] FAIL rnd_branch@%0d: got v%b r%b expected v0 r0", i, instr_valid, fetch_ready); end
      end else if (instr_valid && idr_r) begin
        checks++; if (instr_aligned !== exp_i || instr_compressed !== exp_c) begin fails++; $display("[TB] FAIL rnd_instr@%0d: got %h c%b expected %h c%b", i, instr_aligned, instr_compressed, exp_i, exp_c); end
      end
      acc  = instr_valid && idr_r && !br_r;
      cons = fetch_ready && fv_r;
      if (br_r) begin
        mpc = addr_r & ~32'h1;
        fa  = addr_r & ~32'h3;
      end else begin
        if (acc) begin
          n_acc++;
          if (!exp_c && mpc[1]) exp_cnt++;
          mpc = mpc + (exp_c ? 32'd2 : 32'd4);
        end
        if (cons) fa = fa + 32'd4;
      end
    end
    checks++; if (n_acc < 800) begin fails++; $display("[TB] FAIL rnd_progress: got %0d accepts expected at least 800", n_acc); end
`ifdef INSTR_REALIGNER_PERF_EN
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (misalign_cnt !== 32'(exp_cnt)) begin fails++; $display("[TB] FAIL rnd_cnt: got %0d expected %0d", misalign_cnt, exp_cnt); end
`endif
  endtask

  // Scenario sequence and summary
  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_rdata = 32'h0; id_ready = 1'b0;
    branch = 1'b0; branch_addr = 32'h0;
    test_reset();
    test_aligned_32();
    test_compressed_pair();
    test_straddle();
    test_branch_compressed();
    test_branch_straddle();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
